// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS32 core and its program loader:
// loader state encoding, output decode, opcodes and instruction builder.
package cpu_pkg;

    localparam int MEM_WORDS = 1024;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_RUN  = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    localparam logic [5:0] OP_ALU  = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h0A;
    localparam logic [5:0] OP_HLT  = 6'h07;

    typedef struct packed {
        logic ready;
        logic busy;
        logic run;
        logic err;
    } flags_t;

    function automatic flags_t state_flags(input state_t s);
        flags_t f;
        f       = '0;
        f.ready = (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA) || (s == ST_CSUM);
        f.busy  = f.ready;
        f.run   = (s == ST_RUN);
        f.err   = (s == ST_ERR);
        return f;
    endfunction

    function automatic logic [31:0] mk_itype(input logic [5:0] op, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into 32-bit words and emits a one-cycle
// write strobe with the word and its address after the fourth byte.
module byte_packer #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic [7:0]        din,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              lane_last,
    output logic              we_p1,
    output logic [ADDR_W-1:0] addr_p1,
    output logic [31:0]       word_p1
);

    logic [1:0]      lane_p0;
    logic [2:0][7:0] bytes_p0;

    assign lane_last = (lane_p0 == 2'd3);

    // p0: byte capture into lanes 0..2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_p0  <= '0;
            bytes_p0 <= '0;
        end else if (clear) begin
            lane_p0 <= '0;
        end else if (en) begin
            case (lane_p0)
                2'd0:    bytes_p0[0] <= din;
                2'd1:    bytes_p0[1] <= din;
                2'd2:    bytes_p0[2] <= din;
                default: ;
            endcase
            lane_p0 <= lane_p0 + 2'd1;
        end
    end

    // p1: lane-3 byte completes the word; strobe lasts exactly one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_p1   <= 1'b0;
            addr_p1 <= '0;
            word_p1 <= '0;
        end else begin
            we_p1 <= en && lane_last;
            if (en && lane_last) begin
                addr_p1 <= addr_in;
                word_p1 <= {din, bytes_p0[2], bytes_p0[1], bytes_p0[0]};
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: header/word-count check, word writes
// into instruction memory, XOR checksum, then releases the core.
module prog_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_byte,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              err
);

    localparam logic [16:0]   N_MAX = 17'd1 << ADDR_W;
    localparam logic [ADDR_W:0] WCNT_ONE = (ADDR_W+1)'(1);

    state_t          state;
    flags_t          flags;
    logic [7:0]      acc;
    logic [7:0]      cnt_lo;
    logic [15:0]     n_words;
    logic [ADDR_W:0] wcnt;
    logic [15:0]     n_hdr;
    logic            xfer;
    logic            clear;
    logic            n_ok;
    logic            last_word;
    logic            lane_last;

    assign {s_ready, busy, cpu_run, err} = flags;

    assign xfer      = s_valid && flags.ready;
    assign clear     = start && ((state == ST_IDLE) || (state == ST_RUN) || (state == ST_ERR));
    assign n_hdr     = {s_byte, cnt_lo};
    assign n_ok      = (n_hdr != 16'd0) && (17'(n_hdr) <= N_MAX);
    assign last_word = (17'(wcnt) + 17'd1) == 17'(n_words);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            flags   <= '0;
            acc     <= '0;
            cnt_lo  <= '0;
            n_words <= '0;
            wcnt    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_RUN, ST_ERR: begin
                    if (start) begin
                        state <= ST_HDR0;
                        flags <= state_flags(ST_HDR0);
                        acc   <= '0;
                        wcnt  <= '0;
                    end
                end
                ST_HDR0: begin
                    if (xfer) begin
                        cnt_lo <= s_byte;
                        acc    <= acc ^ s_byte;
                        state  <= ST_HDR1;
                        flags  <= state_flags(ST_HDR1);
                    end
                end
                ST_HDR1: begin
                    if (xfer) begin
                        n_words <= n_hdr;
                        acc     <= acc ^ s_byte;
                        state   <= n_ok ? ST_DATA : ST_ERR;
                        flags   <= state_flags(n_ok ? ST_DATA : ST_ERR);
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        acc <= acc ^ s_byte;
                        if (lane_last) begin
                            wcnt <= wcnt + WCNT_ONE;
                            if (last_word) begin
                                state <= ST_CSUM;
                                flags <= state_flags(ST_CSUM);
                            end
                        end
                    end
                end
                ST_CSUM: begin
                    if (xfer) begin
                        state <= (s_byte == acc) ? ST_RUN : ST_ERR;
                        flags <= state_flags((s_byte == acc) ? ST_RUN : ST_ERR);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    flags <= state_flags(ST_IDLE);
                end
            endcase
        end
    end

    byte_packer #(.ADDR_W(ADDR_W)) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .en       (xfer && (state == ST_DATA)),
        .din      (s_byte),
        .addr_in  (wcnt[ADDR_W-1:0]),
        .lane_last(lane_last),
        .we_p1    (mem_we),
        .addr_p1  (mem_addr),
        .word_p1  (mem_wdata)
    );

endmodule

// File: doc/prog_loader.md
# prog_loader

Upstream program loader for the MIPS32 pipeline core. It accepts a byte stream on a valid/ready handshake and checks a framed header. It assembles little-endian 32-bit instruction words and writes them into the core's 1024-word instruction/data memory through a write port. After the trailing checksum verifies, it asserts `cpu_run` to release the core from hold; the core's PC starts at 0.

## Interface
- `ADDR_W`, default 10: memory word-address width. Maximum program size is 2**ADDR_W words.
- `clk` in 1: single clock. All logic is sampled on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request to begin a load. Honoured only in IDLE, RUN or ERR.
- `s_valid` in 1: upstream byte valid.
- `s_byte` in 8: upstream byte.
- `s_ready` out 1: loader can accept a byte.
- `mem_we` out 1: one-cycle memory write strobe.
- `mem_addr` out ADDR_W: word address for the write.
- `mem_wdata` out 32: word to write.
- `cpu_run` out 1: core release. The core is held while this is low.
- `busy` out 1: high in HDR0, HDR1, DATA and CSUM.
- `err` out 1: high in ERR.

## Operation
- **Frame format:** cnt_lo, cnt_hi, then 4·N payload bytes, then csum.
  - N = {cnt_hi, cnt_lo} is the word count.
  - Each word is sent LSB byte first.
  - csum is the XOR of every preceding byte in the frame, header included.
- **Handshake:** a byte transfers on a rising edge with `s_valid && s_ready`.
  - `s_ready` is a registered function of state: 1 in HDR0/HDR1/DATA/CSUM, 0 otherwise.
  - `s_valid` may stall for any number of cycles. No transfer occurs while it is low.
- **States:** IDLE, HDR0, HDR1, DATA, CSUM, RUN, ERR.
  - IDLE, RUN or ERR, with `start`=1 → HDR0. This clears the checksum accumulator, word counter and byte lane counter.
  - HDR0, on transfer → HDR1. Latches cnt_lo.
  - HDR1, on transfer → DATA if 1 ≤ N ≤ 2**ADDR_W, otherwise ERR.
  - DATA, each transfer places the byte in lane `lane` (0..3) and increments `lane`, which wraps 3→0.
    - On the lane-3 transfer, the assembled word is registered: `mem_we`=1 for exactly the next cycle, `mem_addr` = word index k, `mem_wdata` = {b3,b2,b1,b0}. k then increments.
    - The lane-3 transfer of word N−1 → CSUM.
  - CSUM, on transfer → RUN if byte == accumulator, otherwise ERR.
  - RUN: holds until `start` or reset.
  - ERR: holds until `start` or reset.
- **Memory contents:** words already written are not erased on ERR or on restart.
- **Ignored input:** `start` while `busy` is ignored.
- **Counter widths:**
  - Word counter is ADDR_W+1 bits, so N = 1024 is representable.
  - `mem_addr` is the counter's low ADDR_W bits.
  - The accumulator is 8 bits.

## Timing
- **Reset values:** all outputs are 0 during and after reset (`s_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `cpu_run`, `busy`, `err`). State = IDLE.
- **Reset mid-load:** aborts immediately. `mem_we` drops asynchronously and no partial word is written.
- **Output registration:** `cpu_run`, `busy`, `err` and `s_ready` are registered decodes of state. They change on the edge that enters or leaves the state.
  - `cpu_run` rises on the edge after the csum byte transfers.
  - `cpu_run` falls on the edge that samples `start` in RUN.
- **Write latency:** one cycle from the lane-3 byte transfer to the `mem_we` pulse.
- **Best-case throughput:** one byte per cycle, so a full frame takes 4N+3 transfer cycles.
- **Back-to-back words:** with `s_valid` held high, consecutive `mem_we` pulses are 4 cycles apart.
- **Simultaneous transfer and write:** a byte transfer in the same cycle as a `mem_we` pulse is legal.

## Structure
- **Shared package `cpu_pkg`:**
  - the state encoding enum (3 bits);
  - the opcode localparams, so the bench can build programs symbolically;
  - `MEM_WORDS` = 1024.
- **Sub-module:** the byte-to-word assembler (`lane` counter plus four byte registers plus the write strobe) is a natural sub-module, `byte_packer`.
- The FSM, word counter and checksum stay at top level.

## Test plan
- **Nominal two-word load:** stream 02 00 0A 00 01 28 00 00 00 1C 3D with `s_valid` held high.
  - Expect `mem_we` at addr 0 with data 0x2801000A (ADDI R1,R0,10), then addr 1 with 0x1C000000 (HLT).
  - Expect `cpu_run`=1 the cycle after 3D transfers, and `err`=0.
- **Bad checksum:** send the same frame with csum 3C.
  - Expect both writes, then `err`=1 and `cpu_run`=0.
  - Then `start` → `busy`=1 and `err`=0.
- **Bad header:** N = 0, then N = 0x0401.
  - Expect ERR right after the cnt_hi transfer, zero `mem_we` pulses, and `s_ready`=0.
- **Full-size load with stalls:** N = 0x0400, with `s_valid` randomly deasserted 50% of cycles.
  - Expect 1024 writes with addr 0..1023 and no duplicates or skips.
  - Expect `cpu_run`=1 at the end.
- **Reset mid-load:** pulse `rst_n` low after the 6th payload byte.
  - Expect all outputs 0 immediately and state IDLE.
  - Expect only the word-0 write to have occurred.
- **Reload from RUN, and ignored start:** `start` while in RUN → `cpu_run` falls next edge and a new frame loads correctly. `start` pulsed during DATA has no effect.
